// File: rtl/updown_counter.sv
// Parameterised up/down counter with wrap or saturate, range flags and a registered terminal-count pulse.
// Define UPDOWN_COUNTER_ASSERT_EN to embed concurrent self-checks (no effect on ports or function).
module updown_counter #(
    parameter int unsigned       WIDTH    = 10,
    parameter bit                SATURATE = 1'b0,
    parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             at_end;

    assign at_max = (count_q == MAX_VAL);
    assign at_min = (count_q == '0);

    // Step direction selects which range end counts as the boundary for this cycle.
    assign at_end = mode ? at_max : at_min;

    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        count_d = count_q;
        tc_d    = 1'b0;
        // Branch on en before looking at mode, so an undriven mode cannot disturb a held count.
        if (en) begin
            tc_d = at_end;
            if (at_end && SATURATE) begin
                count_d = count_q;
            end else if (mode) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_VAL;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

`ifdef UPDOWN_COUNTER_ASSERT_EN
    a_step_up: assert property (@(posedge clk) disable iff (!rst)
        (en && mode && !at_max) |=> (count == $past(count) + WIDTH'(1)))
        else $error("updown_counter: up step did not increment");

    a_step_down: assert property (@(posedge clk) disable iff (!rst)
        (en && !mode && !at_min) |=> (count == $past(count) - WIDTH'(1)))
        else $error("updown_counter: down step did not decrement");

    a_hold: assert property (@(posedge clk) disable iff (!rst)
        !en |=> (count == $past(count)))
        else $error("updown_counter: count moved while disabled");

    a_tc_cause: assert property (@(posedge clk) disable iff (!rst)
        tc |-> ($past(en) && (($past(at_max) && $past(mode)) ||
                              ($past(at_min) && !$past(mode)))))
        else $error("updown_counter: tc without a boundary step");
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Randomised and directed bench for updown_counter: one wrapping and one saturating instance
// share stimulus and are compared against an arithmetic reference model.
module tb_updown_counter;

    localparam int W    = 10;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         mode;
    logic [W-1:0] cnt_w, cnt_s;
    logic         amax_w, amin_w, tc_w;
    logic         amax_s, amin_s, tc_s;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: expected count and tc for each instance.
    int mw, ms;
    bit tw, ts;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(W), .SATURATE(1'b0), .RST_VAL('0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .count(cnt_w), .at_max(amax_w), .at_min(amin_w), .tc(tc_w)
    );

    updown_counter #(.WIDTH(W), .SATURATE(1'b1), .RST_VAL('0)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .count(cnt_s), .at_max(amax_s), .at_min(amin_s), .tc(tc_s)
    );

    function automatic int model_next(int c, bit e, logic m, bit sat);
        if (!e) return c;
        if (m === 1'b1) return sat ? ((c < MAXV) ? c + 1 : MAXV) : (c + 1) % (MAXV + 1);
        return sat ? ((c > 0) ? c - 1 : 0) : (c + MAXV) % (MAXV + 1);
    endfunction

    function automatic bit model_tc(int c, bit e, logic m);
        return e && (((m === 1'b1) && (c == MAXV)) || ((m === 1'b0) && (c == 0)));
    endfunction

    // Called at a falling edge; drives inputs, advances the model across one rising edge,
    // and returns at the next falling edge where outputs are sampled.
    task automatic step(input bit e, input logic m);
        en   = e;
        mode = m;
        @(posedge clk);
        tw = model_tc(mw, e, m);
        ts = model_tc(ms, e, m);
        mw = model_next(mw, e, m, 1'b0);
        ms = model_next(ms, e, m, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst  = 1'b0;
        en   = 1'b0;
        mode = 1'b0;
        #3;
        vectors += 4;
        if (cnt_w !== 10'd0) begin miscompares++; $display("FAIL reset_cnt_w: got %0d, expected 0", cnt_w); end
        if (cnt_s !== 10'd0) begin miscompares++; $display("FAIL reset_cnt_s: got %0d, expected 0", cnt_s); end
        if (tc_w !== 1'b0 || tc_s !== 1'b0) begin
            miscompares++; $display("FAIL reset_tc: got %b/%b, expected 0/0", tc_w, tc_s);
        end
        if (amin_w !== 1'b1 || amax_w !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: got min=%b max=%b, expected min=1 max=0", amin_w, amax_w);
        end
        @(negedge clk);
        rst = 1'b1;
        mw = 0; ms = 0; tw = 0; ts = 0;
    endtask

    task automatic test_count_up;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            vectors += 3;
            if (cnt_w !== 10'(i + 1)) begin miscompares++; $display("FAIL up_cnt_w[%0d]: got %0d, expected %0d", i, cnt_w, i + 1); end
            if (cnt_s !== 10'(i + 1)) begin miscompares++; $display("FAIL up_cnt_s[%0d]: got %0d, expected %0d", i, cnt_s, i + 1); end
            if (amin_w !== 1'b0) begin miscompares++; $display("FAIL up_at_min[%0d]: got %b, expected 0", i, amin_w); end
        end
    endtask

    task automatic test_mid_reset;
        for (int k = 0; k < 200 && mw != 974; k++) step(1'b1, 1'b0);
        vectors += 2;
        if (cnt_w !== 10'd974) begin miscompares++; $display("FAIL pre_reset_cnt_w: got %0d, expected 974", cnt_w); end
        if (tc_s !== 1'b1) begin miscompares++; $display("FAIL pre_reset_tc_s: got %b, expected 1", tc_s); end
        #2 rst = 1'b0;
        #1;
        vectors += 3;
        if (cnt_w !== 10'd0) begin miscompares++; $display("FAIL async_reset_cnt_w: got %0d, expected 0", cnt_w); end
        if (tc_s !== 1'b0) begin miscompares++; $display("FAIL async_reset_tc_s: got %b, expected 0", tc_s); end
        if (amin_w !== 1'b1) begin miscompares++; $display("FAIL async_reset_at_min: got %b, expected 1", amin_w); end
        @(negedge clk);
        rst = 1'b1;
        mw = 0; ms = 0; tw = 0; ts = 0;
    endtask

    task automatic test_wrap;
        logic [W-1:0] exp_c [4];
        bit           exp_t [4];
        exp_c = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        exp_t = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        vectors++;
        if (cnt_w !== 10'd1021) begin miscompares++; $display("FAIL wrap_start: got %0d, expected 1021", cnt_w); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            vectors += 4;
            if (cnt_w !== exp_c[i]) begin miscompares++; $display("FAIL wrap_cnt[%0d]: got %0d, expected %0d", i, cnt_w, exp_c[i]); end
            if (tc_w !== exp_t[i]) begin miscompares++; $display("FAIL wrap_tc[%0d]: got %b, expected %b", i, tc_w, exp_t[i]); end
            if (amax_w !== (exp_c[i] == 10'd1023)) begin miscompares++; $display("FAIL wrap_at_max[%0d]: got %b", i, amax_w); end
            if (cnt_s !== 10'(ms)) begin miscompares++; $display("FAIL wrap_side_cnt_s[%0d]: got %0d, expected %0d", i, cnt_s, ms); end
        end
    endtask

    task automatic test_saturate;
        logic [W-1:0] exp_c [4];
        bit           exp_t [4];
        exp_c = '{10'd1, 10'd0, 10'd0, 10'd0};
        exp_t = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 10 && ms != 2; k++) step(1'b1, 1'b0);
        vectors++;
        if (cnt_s !== 10'd2) begin miscompares++; $display("FAIL sat_start: got %0d, expected 2", cnt_s); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            vectors += 3;
            if (cnt_s !== exp_c[i]) begin miscompares++; $display("FAIL sat_cnt[%0d]: got %0d, expected %0d", i, cnt_s, exp_c[i]); end
            if (tc_s !== exp_t[i]) begin miscompares++; $display("FAIL sat_tc[%0d]: got %b, expected %b", i, tc_s, exp_t[i]); end
            if (cnt_w !== 10'(mw)) begin miscompares++; $display("FAIL sat_side_cnt_w[%0d]: got %0d, expected %0d", i, cnt_w, mw); end
        end
    endtask

    task automatic test_dir_change;
        logic [W-1:0] exp_c [4];
        logic         modes [4];
        exp_c = '{10'd975, 10'd976, 10'd975, 10'd974};
        modes = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 200 && mw != 974; k++) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, modes[i]);
            vectors += 2;
            if (cnt_w !== exp_c[i]) begin miscompares++; $display("FAIL dir_cnt[%0d]: got %0d, expected %0d", i, cnt_w, exp_c[i]); end
            if (tc_w !== 1'b0) begin miscompares++; $display("FAIL dir_tc[%0d]: got %b, expected 0", i, tc_w); end
        end
        // Disabled cycles with an undriven mode must hold cleanly.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'bx);
            vectors += 4;
            if (cnt_w !== 10'd974) begin miscompares++; $display("FAIL hold_cnt_w[%0d]: got %0d, expected 974", i, cnt_w); end
            if (tc_w !== 1'b0) begin miscompares++; $display("FAIL hold_tc_w[%0d]: got %b, expected 0", i, tc_w); end
            if (cnt_s !== 10'(ms)) begin miscompares++; $display("FAIL hold_cnt_s[%0d]: got %0d, expected %0d", i, cnt_s, ms); end
            if (tc_s !== 1'b0) begin miscompares++; $display("FAIL hold_tc_s[%0d]: got %b, expected 0", i, tc_s); end
        end
    endtask

    task automatic test_random;
        logic cur_mode = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
                mw = 0; ms = 0; tw = 0; ts = 0;
                #1;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                // Sticky direction produces long runs that reach both range ends.
                if ($urandom_range(0, 19) == 0) cur_mode = ~cur_mode;
                step($urandom_range(0, 4) != 0, cur_mode);
            end
            vectors += 8;
            if (cnt_w !== 10'(mw)) begin miscompares++; $display("FAIL rnd_cnt_w[%0d]: got %0d, expected %0d", n, cnt_w, mw); end
            if (cnt_s !== 10'(ms)) begin miscompares++; $display("FAIL rnd_cnt_s[%0d]: got %0d, expected %0d", n, cnt_s, ms); end
            if (tc_w !== tw) begin miscompares++; $display("FAIL rnd_tc_w[%0d]: got %b, expected %b", n, tc_w, tw); end
            if (tc_s !== ts) begin miscompares++; $display("FAIL rnd_tc_s[%0d]: got %b, expected %b", n, tc_s, ts); end
            if (amax_w !== (mw == MAXV)) begin miscompares++; $display("FAIL rnd_at_max_w[%0d]: got %b", n, amax_w); end
            if (amin_w !== (mw == 0)) begin miscompares++; $display("FAIL rnd_at_min_w[%0d]: got %b", n, amin_w); end
            if (amax_s !== (ms == MAXV)) begin miscompares++; $display("FAIL rnd_at_max_s[%0d]: got %b", n, amax_s); end
            if (amin_s !== (ms == 0)) begin miscompares++; $display("FAIL rnd_at_min_s[%0d]: got %b", n, amin_s); end
        end
    endtask

    initial begin
        test_reset;
        test_count_up;
        test_mid_reset;
        test_wrap;
        test_saturate;
        test_dir_change;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
